// File: rtl/lifo_reverser_pkg.sv
// Shared definitions for the LIFO stream reverser: FSM encoding and default widths.
package lifo_reverser_pkg;

    localparam int B_DEF = 3;
    localparam int W_DEF = 2;

    localparam logic [1:0] ST_FILL    = 2'd0;
    localparam logic [1:0] ST_POP     = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_EMIT    = 2'd3;

endpackage

// File: rtl/lifo_reverser_if.sv
// Bundles the input stream, output stream and stack-side signals of the reverser.
interface lifo_reverser_if
    import lifo_reverser_pkg::*;
#(
    parameter int B = B_DEF
);
    logic         in_valid;
    logic         in_ready;
    logic [B-1:0] in_data;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [B-1:0] out_data;
    logic         out_last;
    logic         lifo_wr;
    logic [B-1:0] lifo_w_data;
    logic         lifo_rd;
    logic [B-1:0] lifo_r_data;
    logic         lifo_full;
    logic         lifo_empty;

    modport slave (
        input  in_valid, in_data, in_last, out_ready, lifo_r_data, lifo_full, lifo_empty,
        output in_ready, out_valid, out_data, out_last, lifo_wr, lifo_w_data, lifo_rd
    );

    modport master (
        output in_valid, in_data, in_last, out_ready, lifo_r_data, lifo_full, lifo_empty,
        input  in_ready, out_valid, out_data, out_last, lifo_wr, lifo_w_data, lifo_rd
    );
endinterface

// File: rtl/lifo_reverser.sv
// Pushes a framed stream onto an external stack, then pops it back out reversed.
// A segment drains when in_last arrives or the stack fills; each word costs POP, CAPTURE, EMIT.
module lifo_reverser
    import lifo_reverser_pkg::*;
#(
    parameter int B = B_DEF,
    parameter int W = W_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    lifo_reverser_if.slave        bus,
    output logic                  err_o
);

    localparam logic [W:0] DEPTH     = {1'b1, {W{1'b0}}};
    localparam logic [W:0] LAST_SLOT = DEPTH - {{W{1'b0}}, 1'b1};

    logic [1:0]   state_q, state_d;
    logic [W:0]   cnt_q, cnt_d;
    logic         last_seen_q, last_seen_d;
    logic [B-1:0] out_data_q, out_data_d;
    logic         err_q, err_d;

    logic in_ready, out_valid, out_last, wr, rd;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_seen_d = last_seen_q;
        out_data_d  = out_data_q;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        out_last    = 1'b0;
        wr          = 1'b0;
        rd          = 1'b0;

        case (state_q)
            ST_FILL: begin
                in_ready = (cnt_q < DEPTH);
                if (bus.in_valid && in_ready) begin
                    wr          = 1'b1;
                    cnt_d       = cnt_q + {{W{1'b0}}, 1'b1};
                    last_seen_d = bus.in_last;
                    if (bus.in_last || (cnt_q == LAST_SLOT)) begin
                        state_d = ST_POP;
                    end
                end
            end
            ST_POP: begin
                rd      = 1'b1;
                cnt_d   = cnt_q - {{W{1'b0}}, 1'b1};
                state_d = ST_CAPTURE;
            end
            // Stack read data is valid the cycle after the pop strobe.
            ST_CAPTURE: begin
                out_data_d = bus.lifo_r_data;
                state_d    = ST_EMIT;
            end
            ST_EMIT: begin
                out_valid = 1'b1;
                out_last  = last_seen_q && (cnt_q == '0);
                if (bus.out_ready) begin
                    state_d = (cnt_q == '0) ? ST_FILL : ST_POP;
                end
            end
            default: state_d = ST_FILL;
        endcase

        err_d = err_q | (rd & bus.lifo_empty) | (wr & bus.lifo_full);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_FILL;
            cnt_q       <= '0;
            last_seen_q <= 1'b0;
            out_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_seen_q <= last_seen_d;
            out_data_q  <= out_data_d;
            err_q       <= err_d;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid;
    assign bus.out_data    = out_data_q;
    assign bus.out_last    = out_last;
    assign bus.lifo_wr     = wr;
    assign bus.lifo_w_data = bus.in_data;
    assign bus.lifo_rd     = rd;
    assign err_o           = err_q;

endmodule

// File: tb/tb_lifo_reverser.sv
// Scoreboard bench for lifo_reverser with a behavioural 4-deep stack beside the DUT.
module tb_lifo_reverser;
    import lifo_reverser_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic err;
    logic force_empty = 1'b0;

    always #5 clk = ~clk;

    lifo_reverser_if #(.B(3)) bus();

    lifo_reverser #(.B(3), .W(2)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus),
        .err_o  (err)
    );

    // Behavioural stack: read data appears the cycle after a pop.
    logic [2:0] mem [4];
    logic [2:0] sp;
    logic [2:0] r_data;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp     <= 3'd0;
            r_data <= 3'd0;
        end else if (bus.lifo_wr && sp < 3'd4) begin
            mem[sp[1:0]] <= bus.lifo_w_data;
            sp           <= sp + 3'd1;
        end else if (bus.lifo_rd && sp > 3'd0) begin
            r_data <= mem[sp[1:0] - 2'd1];
            sp     <= sp - 3'd1;
        end
    end

    assign bus.lifo_r_data = r_data;
    assign bus.lifo_full   = (sp == 3'd4);
    assign bus.lifo_empty  = force_empty || (sp == 3'd0);

    int total = 0;
    int bad   = 0;
    int hs    = 0;
    int wrp   = 0;
    int rdp   = 0;

    typedef struct {
        logic [2:0] d;
        logic       l;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_w(input logic [2:0] d, input logic l);
        exp_t e;
        e.d = d;
        e.l = l;
        sb.push_back(e);
    endtask

    task automatic send(input logic [2:0] d, input logic l);
        int t;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        t = 0;
        while (!bus.in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk("send_timeout", 1, 0);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((sb.size() != 0 || !bus.in_ready) && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) chk("drain_timeout", 1, 0);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n) begin
            if (bus.lifo_wr) wrp++;
            if (bus.lifo_rd) rdp++;
            if (bus.lifo_wr && bus.lifo_rd) chk("wr_rd_overlap", 1, 0);
            if (bus.out_valid && bus.out_ready) begin
                hs++;
                if (sb.size() == 0) begin
                    chk("unexpected_out", {29'd0, bus.out_data}, 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    chk("out_data", {29'd0, bus.out_data}, {29'd0, e.d});
                    chk("out_last", {31'd0, bus.out_last}, {31'd0, e.l});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int w0, r0, n, h0;
        logic [2:0] cd;
        logic cl, stable, rdseen;

        bus.in_valid  = 1'b0;
        bus.in_data   = 3'd0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 0);
        chk("rst_out_data",  {29'd0, bus.out_data}, 0);
        chk("rst_out_last",  {31'd0, bus.out_last}, 0);
        chk("rst_lifo_wr",   {31'd0, bus.lifo_wr}, 0);
        chk("rst_lifo_rd",   {31'd0, bus.lifo_rd}, 0);
        chk("rst_err",       {31'd0, err}, 0);
        chk("rst_in_ready",  {31'd0, bus.in_ready}, 1);
        rst_n = 1'b1;

        // Frame 5,2,7 reverses to 7,2,5.
        w0 = wrp;
        r0 = rdp;
        expect_w(3'd7, 1'b0);
        expect_w(3'd2, 1'b0);
        expect_w(3'd5, 1'b1);
        send(3'd5, 1'b0);
        send(3'd2, 1'b0);
        send(3'd7, 1'b1);
        wait_idle();
        chk("t1_wr_pulses", wrp - w0, 3);
        chk("t1_rd_pulses", rdp - r0, 3);
        chk("t1_err", {31'd0, err}, 0);

        // Frame 1..6 splits into a full segment and a tail segment.
        expect_w(3'd4, 1'b0);
        expect_w(3'd3, 1'b0);
        expect_w(3'd2, 1'b0);
        expect_w(3'd1, 1'b0);
        expect_w(3'd6, 1'b0);
        expect_w(3'd5, 1'b1);
        send(3'd1, 1'b0);
        send(3'd2, 1'b0);
        send(3'd3, 1'b0);
        send(3'd4, 1'b0);
        @(negedge clk);
        chk("t2_in_ready_seg1", {31'd0, bus.in_ready}, 0);
        send(3'd5, 1'b0);
        send(3'd6, 1'b1);
        @(negedge clk);
        chk("t2_in_ready_seg2", {31'd0, bus.in_ready}, 0);
        wait_idle();

        // Single word: three-cycle latency, in_ready back right after.
        expect_w(3'd4, 1'b1);
        send(3'd4, 1'b1);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t3_latency", n, 3);
        @(negedge clk);
        chk("t3_in_ready_after", {31'd0, bus.in_ready}, 1);
        chk("t3_out_valid_after", {31'd0, bus.out_valid}, 0);

        // Backpressure holds the output and stalls pops.
        bus.out_ready = 1'b0;
        expect_w(3'd6, 1'b0);
        expect_w(3'd3, 1'b1);
        send(3'd3, 1'b0);
        send(3'd6, 1'b1);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        cd = bus.out_data;
        cl = bus.out_last;
        stable = 1'b1;
        rdseen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (!bus.out_valid || bus.out_data !== cd || bus.out_last !== cl) stable = 1'b0;
            if (bus.lifo_rd) rdseen = 1'b1;
        end
        chk("t4_held_data", {29'd0, cd}, 6);
        chk("t4_stable", {31'd0, stable}, 1);
        chk("t4_no_pop", {31'd0, rdseen}, 0);
        bus.out_ready = 1'b1;
        wait_idle();

        // Reset after two of four words emitted discards the rest.
        expect_w(3'd4, 1'b0);
        expect_w(3'd3, 1'b0);
        expect_w(3'd2, 1'b0);
        expect_w(3'd1, 1'b1);
        h0 = hs;
        send(3'd1, 1'b0);
        send(3'd2, 1'b0);
        send(3'd3, 1'b0);
        send(3'd4, 1'b1);
        n = 0;
        while (hs < h0 + 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("t5_timeout", 1, 0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_out_valid", {31'd0, bus.out_valid}, 0);
        chk("t5_cnt", {29'd0, dut.cnt_q}, 0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5_in_ready", {31'd0, bus.in_ready}, 1);
        chk("t5_out_valid_post", {31'd0, bus.out_valid}, 0);

        // Pop against an empty stack raises sticky err.
        expect_w(3'd5, 1'b1);
        send(3'd5, 1'b1);
        @(negedge clk);
        force_empty = 1'b1;
        chk("t6_err_before", {31'd0, err}, 0);
        @(negedge clk);
        force_empty = 1'b0;
        chk("t6_err_set", {31'd0, err}, 1);
        wait_idle();
        repeat (3) @(negedge clk);
        chk("t6_err_sticky", {31'd0, err}, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_err_reset", {31'd0, err}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lifo_reverser.md
# lifo_reverser

Stream-reversal controller that drives the write side and the read side of the team's stack buffer. It accepts a framed input stream over valid/ready and pushes each word onto the attached stack. When a frame ends or the stack fills, it pops the stack back out and presents the words, last-in first, on a valid/ready output. It sits between an upstream producer and a downstream consumer, with the stack instance beside it in an integration wrapper.

## Interface
- B, 3, bits per data word; must match the attached stack.
- W, 2, stack address bits; stack depth D = 2**W.
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  input word present.
- in_ready  out  1  block accepts the input word this cycle.
- in_data  in  B  input word.
- in_last  in  1  marks the final word of a frame.
- out_valid  out  1  output word present.
- out_ready  in  1  consumer accepts the output word.
- out_data  out  B  reversed output word.
- out_last  out  1  marks the final word of a reversed frame.
- lifo_wr  out  1  push strobe to the stack.
- lifo_w_data  out  B  push data; equals in_data.
- lifo_rd  out  1  pop strobe to the stack.
- lifo_r_data  in  B  stack read data; holds the popped word in the cycle after lifo_rd.
- lifo_full  in  1  stack full flag; monitored only.
- lifo_empty  in  1  stack empty flag; monitored only.
- err  out  1  sticky protocol-violation flag.

## Operation
- Internal counter cnt has width W+1 and range 0..D. It tracks words held in the stack. The flag last_seen records whether the current segment ended on in_last.
- FSM states:
  - FILL: in_ready = (cnt < D). On an accept, assert lifo_wr combinationally, increment cnt, and latch last_seen = in_last. Move to POP if in_last=1 or cnt+1 == D.
  - POP: assert lifo_rd for exactly one cycle, decrement cnt, then move to CAPTURE.
  - CAPTURE: register lifo_r_data into out_data, then move to EMIT.
  - EMIT: out_valid = 1. out_last = last_seen && (cnt == 0). On out_valid & out_ready, go to FILL if cnt == 0, otherwise go to POP.
- lifo_wr and lifo_rd are never asserted in the same cycle. They are never asserted outside FILL and POP respectively.
- When a segment ends on a full stack without in_last, its final word has out_last=0. The frame continues in the next segment.
- err sets and stays set until reset if either condition occurs:
  - lifo_rd is asserted while lifo_empty=1.
  - lifo_wr is asserted while lifo_full=1.
- The attached stack must be reset in the same cycle as this block.

## Timing
- Reset values:
  - State FILL, cnt=0, last_seen=0.
  - out_valid=0, out_data=0, out_last=0.
  - lifo_wr=0, lifo_rd=0, err=0.
  - in_ready=1.
- Drain latency: the first output appears 3 cycles after the terminating accept (POP, CAPTURE, EMIT).
- Drain throughput: one word per 3 cycles with out_ready held high.
- Fill throughput: one word per cycle.
- in_ready is 0 from the cycle after the terminating accept until the final EMIT handshake.
- Output handshake: out_data, out_last and out_valid hold stable while out_valid=1 and out_ready=0. No pop is issued during backpressure.
- Reset mid-operation: all registers return to reset values immediately. A partially drained frame is discarded.

## Structure
- Shared package holds:
  - State encoding: FILL=2'd0, POP=2'd1, CAPTURE=2'd2, EMIT=2'd3.
  - Default widths: B=3, W=2.
- Single module with no sub-module. Stack instantiation belongs in a separate wrapper, lifo_reverser_top.

## Test plan
All scenarios use B=3, W=2.
- Frame 5,2,7 with in_last on 7, out_ready=1 -> output 7,2,5 with out_last only on 5. Three lifo_wr pulses, then three lifo_rd pulses. err=0.
- Frame 1..6 with in_last on 6 -> first segment 4,3,2,1 with out_last=0, then 6,5 with out_last on 5. in_ready=0 while each segment drains.
- Single word 4 with in_last -> out 4 with out_last=1, 3 cycles after the accept. in_ready returns to 1 the cycle after the handshake.
- out_ready held low for 5 cycles in EMIT -> out_valid, out_data and out_last stable. lifo_rd=0 throughout.
- Reset asserted after 2 of 4 words are emitted -> out_valid=0 and cnt=0 immediately. in_ready=1 after release.
- lifo_empty forced to 1 during POP -> err=1 from the next edge and held until reset.
